vga_timing_gen: RTL

Parametrised raster timing generator for the VDP display path. It replaces fixed 640x480 counters with configurable horizontal and vertical timing and a pixel-clock divider. It adds a lead-ahead fetch coordinate stream so that VRAM/CRAM read latency is hidden from the pixel output. It also provides a scaled display window, so the 256x192 VDP image can be centred and pixel-doubled inside the active area, plus line/frame strobes and a frame counter for the display interface.

---
 rtl/vga_timing_gen.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Parametrised raster timing generator with pixel divider, lead-ahead
//           fetch coordinates and a scaled display window.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIX_DIV    = 4,
  parameter int LEAD       = 8,
  parameter int WIN_X      = 64,
  parameter int WIN_Y      = 48,
  parameter int WIN_W      = 256,
  parameter int WIN_H      = 192,
  parameter int SCALE_LOG2 = 1,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW        = $clog2(H_TOTAL),
  localparam int RW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  output logic          pix_en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          active,
  output logic          HSync,
  output logic          VSync,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt,
  output logic          fetch_valid,
  output logic [7:0]    fetch_x,
  output logic [7:0]    fetch_y
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] C_DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] C_H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [RW-1:0] C_V_LAST   = RW'(V_TOTAL - 1);
  localparam logic [CW-1:0] C_LEAD     = CW'(LEAD);
  localparam logic [31:0]   C_HA       = 32'(H_ACTIVE);
  localparam logic [31:0]   C_VA       = 32'(V_ACTIVE);
  localparam logic [31:0]   C_HS_BEG   = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0]   C_HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0]   C_VS_BEG   = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0]   C_VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [31:0]   C_WX       = 32'(WIN_X);
  localparam logic [31:0]   C_WY       = 32'(WIN_Y);
  localparam logic [31:0]   C_WX_END   = 32'(WIN_X + (WIN_W << SCALE_LOG2));
  localparam logic [31:0]   C_WY_END   = 32'(WIN_Y + (WIN_H << SCALE_LOG2));

  if (LEAD >= H_TOTAL) begin : g_chk_lead
    $error("vga_timing_gen: LEAD must be smaller than H_TOTAL");
  end
  if ((WIN_X + (WIN_W << SCALE_LOG2) > H_ACTIVE) ||
      (WIN_Y + (WIN_H << SCALE_LOG2) > V_ACTIVE)) begin : g_chk_win
    $error("vga_timing_gen: scaled window exceeds the active area");
  end
  if ((WIN_W > 256) || (WIN_H > 256)) begin : g_chk_size
    $error("vga_timing_gen: window source size exceeds 256");
  end

  // {valid, x, y} for a fetch position; coordinates are forced to 0 outside the window
  function automatic logic [16:0] f_win(input logic [CW-1:0] h, input logic [RW-1:0] v);
    logic [31:0] hx, vy, dx, dy;
    hx = 32'(h);
    vy = 32'(v);
    dx = (hx - C_WX) >> SCALE_LOG2;
    dy = (vy - C_WY) >> SCALE_LOG2;
    if ((hx >= C_WX) && (hx < C_WX_END) && (vy >= C_WY) && (vy < C_WY_END))
      f_win = {1'b1, 8'(dx), 8'(dy)};
    else
      f_win = 17'd0;
  endfunction

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_col, r_fh;
  logic [RW-1:0] r_row, r_fv;
  logic [15:0]   r_frame_cnt;
  logic          r_active, r_hsync, r_vsync;
  logic          r_fvalid;
  logic [7:0]    r_fx, r_fy;

  logic          w_pix_en, w_frame_wrap;
  logic [DW-1:0] w_div_nxt;
  logic [CW-1:0] w_col_nxt, w_fh_nxt;
  logic [RW-1:0] w_row_nxt, w_fv_nxt;
  logic [16:0]   w_win_nxt;

  assign w_pix_en     = (r_div == C_DIV_LAST);
  assign w_frame_wrap = w_pix_en && !restart && (r_col == C_H_LAST) && (r_row == C_V_LAST);

  always_comb begin
    w_div_nxt = r_div + DW'(1);
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    w_fh_nxt  = r_fh;
    w_fv_nxt  = r_fv;
    if (restart) begin
      w_div_nxt = '0;
      w_col_nxt = '0;
      w_row_nxt = '0;
      w_fh_nxt  = C_LEAD;
      w_fv_nxt  = '0;
    end else if (w_pix_en) begin
      w_div_nxt = '0;
      w_col_nxt = (r_col == C_H_LAST) ? '0 : r_col + CW'(1);
      if (r_col == C_H_LAST)
        w_row_nxt = (r_row == C_V_LAST) ? '0 : r_row + RW'(1);
      // the fetch pair follows identical wrap rules, just LEAD ticks ahead
      w_fh_nxt = (r_fh == C_H_LAST) ? '0 : r_fh + CW'(1);
      if (r_fh == C_H_LAST)
        w_fv_nxt = (r_fv == C_V_LAST) ? '0 : r_fv + RW'(1);
    end
  end

  assign w_win_nxt = f_win(w_fh_nxt, w_fv_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_fh        <= C_LEAD;
      r_fv        <= '0;
      r_frame_cnt <= '0;
      r_active    <= 1'b1;
      r_hsync     <= ~HS_POL;
      r_vsync     <= ~VS_POL;
      {r_fvalid, r_fx, r_fy} <= f_win(C_LEAD, '0);
    end else begin
      r_div       <= w_div_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_fh        <= w_fh_nxt;
      r_fv        <= w_fv_nxt;
      if (w_frame_wrap)
        r_frame_cnt <= r_frame_cnt + 16'd1;
      // decoded from the next counter values so they line up with col/row
      r_active <= (32'(w_col_nxt) < C_HA) && (32'(w_row_nxt) < C_VA);
      r_hsync  <= ((32'(w_col_nxt) >= C_HS_BEG) && (32'(w_col_nxt) < C_HS_END)) ? HS_POL : ~HS_POL;
      r_vsync  <= ((32'(w_row_nxt) >= C_VS_BEG) && (32'(w_row_nxt) < C_VS_END)) ? VS_POL : ~VS_POL;
      {r_fvalid, r_fx, r_fy} <= w_win_nxt;
    end
  end

  assign pix_en      = w_pix_en;
  assign col         = r_col;
  assign row         = r_row;
  assign active      = r_active;
  assign HSync       = r_hsync;
  assign VSync       = r_vsync;
  assign line_start  = w_pix_en && (r_col == '0);
  assign frame_start = w_pix_en && (r_col == '0) && (r_row == '0);
  assign frame_cnt   = r_frame_cnt;
  assign fetch_valid = r_fvalid;
  assign fetch_x     = r_fx;
  assign fetch_y     = r_fy;

endmodule

`default_nettype wire
